// File: rtl/sd_sector_reader.sv
// ============================================================================
//  Module   : sd_sector_reader
//  Purpose  : Issues one SD block read per requested sector and captures the
//             512 returned bytes into a local buffer with an XOR checksum.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sd_sector_reader #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [22:0] sector,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  checksum,
  input  logic [8:0]  buf_addr,
  output logic [7:0]  buf_data,
  output logic        sd_rd,
  output logic [31:0] sd_address,
  input  logic [7:0]  sd_dout,
  input  logic        sd_byte_available,
  input  logic        sd_ready
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_READY = 3'd1,
    S_ISSUE      = 3'd2,
    S_RECV       = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] c_tmo_last = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]       c_last_byte = 9'd511;

  state_t           r_state;
  logic [8:0]       r_cnt;
  logic [CNT_W-1:0] r_tmo;
  logic [7:0]       r_mem [0:511];

  logic w_active;
  logic w_event;
  logic w_byte;
  logic w_tmo_hit;

  // Progress in any waiting state restarts the timeout window.
  assign w_active  = (r_state == S_WAIT_READY) || (r_state == S_ISSUE) || (r_state == S_RECV);
  assign w_byte    = (r_state == S_RECV) && sd_byte_available;
  assign w_event   = ((r_state == S_WAIT_READY) && sd_ready) ||
                     ((r_state == S_ISSUE) && !sd_ready) ||
                     w_byte;
  assign w_tmo_hit = (r_tmo == c_tmo_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      sd_rd      <= 1'b0;
      sd_address <= 32'd0;
      checksum   <= 8'd0;
      r_cnt      <= 9'd0;
      r_tmo      <= '0;
    end else begin
      done <= 1'b0;

      if (w_active && !w_event) begin
        if (w_tmo_hit) begin
          r_state <= S_IDLE;
          error   <= 1'b1;
          busy    <= 1'b0;
          sd_rd   <= 1'b0;
          r_tmo   <= '0;
        end else begin
          r_tmo <= r_tmo + 1'b1;
        end
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            r_state <= S_IDLE;
            if (start) begin
              sd_address <= {sector, 9'd0};
              error      <= 1'b0;
              checksum   <= 8'd0;
              r_cnt      <= 9'd0;
              r_tmo      <= '0;
              busy       <= 1'b1;
              r_state    <= S_WAIT_READY;
            end
          end
          S_WAIT_READY: begin
            r_state <= S_ISSUE;
            sd_rd   <= 1'b1;
            r_tmo   <= '0;
          end
          S_ISSUE: begin
            r_state <= S_RECV;
            sd_rd   <= 1'b0;
            r_tmo   <= '0;
          end
          S_RECV: begin
            checksum <= checksum ^ sd_dout;
            r_tmo    <= '0;
            if (r_cnt == c_last_byte) begin
              r_state <= S_DONE;
              done    <= 1'b1;
              busy    <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Buffer has no reset so it maps onto block RAM; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_byte) begin
      r_mem[r_cnt] <= sd_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_data <= 8'd0;
    end else begin
      buf_data <= r_mem[buf_addr];
    end
  end

endmodule

`default_nettype wire

// File: doc/sd_sector_reader.md
Name: sd_sector_reader

Overview:
- Sequencer that sits directly upstream and downstream of the SD controller.
- Upstream role: waits for controller ready, issues one block read (rd + byte address) for a requested sector.
- Downstream role: counts the 512 bytes returned via dout/byte_available, stores them in an internal 512x8 sector buffer and computes an XOR checksum.
- Presents the buffer to the rest of the design through a synchronous random-access read port; signals completion or timeout error.

Parameters:
- TIMEOUT_CYCLES, 1000000: max idle cycles allowed in WAIT_READY, ISSUE or between bytes in RECV before entering ERROR (25 MHz -> 40 ms).
- CNT_W, 20: width of timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock (25 MHz), all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to read sector; honoured only when busy=0
- sector  input  23  sector index; captured on accepted start
- busy  output  1  high from accepted start until DONE/ERROR exit
- done  output  1  one-cycle pulse: 512 bytes stored
- error  output  1  sticky timeout flag; cleared by next accepted start or reset
- checksum  output  8  XOR of all bytes of last read; valid when done pulses
- buf_addr  input  9  buffer read address
- buf_data  output  8  buffer byte at buf_addr, registered, 1-cycle latency
- sd_rd  output  1  to controller rd
- sd_address  output  32  to controller address = {sector, 9'b0}
- sd_dout  input  8  from controller dout
- sd_byte_available  input  1  from controller; one pulse per byte
- sd_ready  input  1  from controller ready

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy=0, done=0, error=0, sd_rd=0, sd_address=0, checksum=0, byte counter=0, timeout counter=0, buf_data=0. Buffer contents not cleared.
- IDLE: start=1 -> latch sd_address={sector,9'b0}, clear error, checksum, byte counter and timeout counter -> WAIT_READY; busy=1 next cycle.
- WAIT_READY: sd_ready=1 -> ISSUE.
- ISSUE: sd_rd=1. Controller acceptance is sd_ready sampled 0 while sd_rd=1 -> deassert sd_rd next cycle, -> RECV.
- RECV: each cycle with sd_byte_available=1:
  - write buffer[cnt]=sd_dout;
  - checksum ^= sd_dout;
  - cnt++.
  - Byte with cnt==511 -> DONE; counter does not wrap inside a read.
- DONE: done=1 for exactly one cycle, busy=0 in the same cycle -> IDLE.
- ERROR: error=1, busy=0 -> IDLE in the same transition. error stays high until the next accepted start or reset.
- Timeout: counter resets on every state change and on every byte in RECV, increments otherwise in WAIT_READY/ISSUE/RECV. Reaching TIMEOUT_CYCLES -> ERROR, sd_rd forced 0. Bytes already written remain in buffer.
- start while busy=1: ignored, no effect on sector latch.
- sd_byte_available outside RECV: ignored, no buffer write, no checksum change.
- Simultaneous byte and timeout in RECV: byte wins; it is stored and the counter resets.
- Buffer read port: buf_data <= buffer[buf_addr] every cycle, independent of state. Reading while RECV writes the same address returns the old byte (read-before-write).
- Reset mid-read: immediate return to IDLE next edge, sd_rd=0. A subsequent start must re-wait sd_ready before issuing.
- Latency: start -> sd_rd high is at least 2 cycles (WAIT_READY, ISSUE). Last byte -> done pulse is 1 cycle.

Test Plan:
- Nominal read: reset, sector=23'd3, start; controller model accepts, sends bytes 0x00..0xFF twice -> sd_address=0x00000600, sd_rd high until sd_ready low, done pulse 1 cycle after 512th byte, checksum=0x00, buf_addr=0x1FF -> buf_data=0xFF next cycle.
- Not-ready controller: hold sd_ready=0 for 100 cycles then 1 -> sd_rd stays 0 for those 100 cycles, then rises; read completes normally.
- Timeout: TIMEOUT_CYCLES=50; stop bytes after 10 -> error=1 exactly 50 cycles after the last byte, busy=0, sd_rd=0, buffer[0..9] correct; next start clears error.
- Spurious/ignored inputs: byte_available pulses in IDLE, and start pulses with sector=7 during RECV -> no buffer change, sd_address unchanged, single done per read.
- Reset mid-RECV after 200 bytes -> next cycle busy=0, sd_rd=0, done=0, error=0; new start for sector 0 -> sd_address=0, full read correct.
- Back-to-back reads: start on the cycle after done with a different sector -> accepted, checksum recomputed from 0, buf_data reflects new data.
